fp_round_stage: RTL
===================

# fp_round_stage

Two-stage pipelined normalize/round/pack stage placed directly downstream of the multiply/divide unit. It accepts the unrounded significand, exponent, sign and special-case word produced for `fmul`/`fdiv` and performs post-normalization, denormalization and IEEE-754 rounding in one of four modes. It packs the result into binary64 or binary32 format and raises exception flags. A valid/ready handshake lets it stall against the register-file writeback.

## Interface
- `BIAS_D`, 1023: binary64 exponent bias.
- `BIAS_S`, 127: binary32 exponent bias.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input operation valid.
- `in_ready`  out  1  stage can accept input this cycle.
- `fq`  in  57  unrounded significand. `fq[56:55]` are integer bits, `fq[54:0]` are fraction bits; `fq[0]` is already sticky.
- `eq`  in  13  unbiased exponent, two's complement.
- `sq`  in  1  result sign.
- `flq`  in  58  special word:
  - `[57]` ZERO, `[56]` INF, `[55]` NAN.
  - `[54]` INV, `[53]` DBZ.
  - `[52:0]` NaN significand.
- `db`  in  1  1 = binary64, 0 = binary32.
- `rm`  in  2  rounding mode: 00 RNE, 01 RZ, 10 RU (toward +inf), 11 RD (toward -inf).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_res`  out  64  packed result. For binary32, `[63:32]` is zero.
- `out_flags`  out  5  `{INV, DBZ, OVF, UNF, INX}`.

## Operation
- **S1, normalize:**
  - If `fq[56]`: shift right 1 with sticky OR; e = eq+1.
  - Else if `fq[55]`: no shift; e = eq.
  - Else: shift left 1; e = eq−1.
  - eb = e + bias, computed as a 14-bit signed value.
  - `tiny` = (eb ≤ 0). When tiny, shift right by 1−eb (capped at 58), OR the shifted-out bits into sticky, and set eb = 0.
- **Round positions:**
  - binary64: fraction = `m[54:3]`, round bit = `m[2]`, sticky = `|m[1:0]`.
  - binary32: fraction = `m[54:32]`, round bit = `m[31]`, sticky = `|m[30:0]`.
- **S2, round:**
  - Increment when:
    - RNE: R & (S | lsb).
    - RZ: never.
    - RU: !sq & (R|S).
    - RD: sq & (R|S).
  - INX = R | S.
  - Carry out of the hidden bit increments eb. A denormal that rounds up into the hidden bit becomes eb = 1.
- **Overflow:** eb ≥ 2047 (binary64) or ≥ 255 (binary32).
  - OVF = INX = 1.
  - Result is ±inf for RNE, for RU with positive sign, and for RD with negative sign.
  - Otherwise the result is ±max-finite.
- **Underflow:** UNF = tiny & INX.
- **Specials:** any of `flq[57:55]` overrides the arithmetic path, with priority NAN > INF > ZERO.
  - NAN: sign 0, exponent all ones, fraction = `flq[51:0]` (binary64) or `flq[51:29]` (binary32), with the top fraction bit forced to 1.
  - INF: ±inf with sign sq.
  - ZERO: ±0 with sign sq.
  - OVF, UNF and INX are 0 for specials.
- INV = `flq[54]` and DBZ = `flq[53]` are passed through for all operations.

## Timing
- Latency is 2 cycles from input handshake (`in_valid & in_ready`) to `out_valid`. Throughput is 1 operation per cycle.
- Each stage register has a valid bit.
  - S2 loads when S2 is empty or `out_ready` is high.
  - S1 loads when S1 is empty or S1 is advancing into S2.
  - `in_ready` = !s1_valid | s1_advance. It is combinational from `out_ready`.
- A full pipe with `out_ready` = 0 holds all data stable, drives `in_ready` = 0, and drops nothing.
- A simultaneous input accept and output drain with a full pipe moves every stage forward in the same cycle.
- Reset:
  - `out_valid`, `out_res` and `out_flags` are 0; both valid bits are 0.
  - A reset mid-operation discards in-flight operations, and nothing is emitted afterwards.
- `rm` and `db` are sampled with the input and travel with the operation.

## Configuration
- `FP_RND_FTZ_EN` defined: tiny results are flushed to ±0 with sign sq, and UNF = INX = 1. The denormal shifter is not built.
- `FP_RND_FTZ_EN` undefined: gradual underflow as described in S1.

## Test plan
- **Simple binary64:** `fq`=57'h0C0_0000_0000_0000, `eq`=0, `sq`=0, `db`=1, RNE -> `out_res`=64'h3FF8_0000_0000_0000, flags 0, `out_valid` two cycles after the handshake.
- **RNE ties:**
  - `fq`=57'h080_0000_0000_0004 -> 64'h3FF0_0000_0000_0000 with INX.
  - `fq`=57'h080_0000_0000_000C -> 64'h3FF0_0000_0000_0002 with INX.
- **Overflow:** `fq`=57'h080_0000_0000_0000, `eq`=1024.
  - RNE -> 64'h7FF0_0000_0000_0000 with OVF and INX.
  - RZ -> 64'h7FEF_FFFF_FFFF_FFFF with OVF and INX.
- **Underflow:** `fq`=57'h080_0000_0000_0000, `eq`=−1023.
  - Without FTZ -> 64'h0008_0000_0000_0000, UNF = 0.
  - With FTZ -> 64'h0 with UNF and INX.
- **NaN special:** `flq[55]`=1, `flq[54]`=1, `flq[51:0]`=0 -> 64'h7FF8_0000_0000_0000 with INV.
  - Binary32 variant with the same inputs -> 64'h0000_0000_7FC0_0000.
- **Back-pressure:** hold `out_ready`=0 and issue 3 back-to-back operations.
  - Exactly 2 are accepted and `in_ready` falls to 0.
  - After `out_ready` rises, all 3 results emerge in order with no loss or duplication.

Source files
------------

// File: rtl/fp_round_stage_if.sv
// Handshake and data bundle for fp_round_stage: operation in, packed result out.
// The slave modport is the rounding stage's view, the master is the producer/consumer side.
interface fp_round_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] fq;
    logic [12:0] eq;
    logic        sq;
    logic [57:0] flq;
    logic        db;
    logic [1:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic [4:0]  out_flags;

    modport master (
        output in_valid, fq, eq, sq, flq, db, rm, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

    modport slave (
        input  in_valid, fq, eq, sq, flq, db, rm, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );
endinterface

// File: rtl/fp_round_stage.sv
// Two-stage normalize/denormalize (S1) and round/pack (S2) stage for fmul/fdiv results.
// Define FP_RND_FTZ_EN to flush tiny results to zero instead of building the denormal shifter.
module fp_round_stage #(
    parameter int BIAS_D = 1023,
    parameter int BIAS_S = 127
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_round_stage_if.slave bus
);
    localparam logic [13:0] L_BIAS_D = 14'(BIAS_D);
    localparam logic [13:0] L_BIAS_S = 14'(BIAS_S);
    localparam logic [13:0] L_EMAX_D = 14'd2047;
    localparam logic [13:0] L_EMAX_S = 14'd255;
    localparam logic [1:0]  RM_RNE   = 2'b00;
    localparam logic [1:0]  RM_RZ    = 2'b01;
    localparam logic [1:0]  RM_RU    = 2'b10;

    logic        r_s1_valid;
    logic        r_s2_valid;
    logic        w_s2_open;
    logic        w_s1_adv;
    logic        w_in_ready;
    logic        w_s1_load;

    logic [13:0] w_eq_ext;
    logic [13:0] w_e;
    logic [13:0] w_eb;
    logic        w_tiny;
    logic [55:0] w_m_norm;
    logic [55:0] w_m_s1;
    logic [13:0] w_eb_s1;

    logic [55:0] r_s1_m;
    logic [13:0] r_s1_eb;
    logic        r_s1_tiny;
    logic        r_s1_sq;
    logic        r_s1_db;
    logic [1:0]  r_s1_rm;
    logic        r_s1_zero;
    logic        r_s1_inf;
    logic        r_s1_nan;
    logic        r_s1_inv;
    logic        r_s1_dbz;
    logic [50:0] r_s1_nan_frac;

    logic        w_r;
    logic        w_s;
    logic        w_lsb;
    logic        w_inc;
    logic        w_inx;
    logic [53:0] w_sum_d;
    logic [24:0] w_sum_s;
    logic        w_carry;
    logic        w_hid;
    logic [13:0] w_eb_r;
    logic        w_ovf;
    logic        w_to_inf;
    logic        w_f_ovf;
    logic        w_f_unf;
    logic        w_f_inx;
    logic [63:0] w_res;
    logic [4:0]  w_flags;

    logic [63:0] r_out_res;
    logic [4:0]  r_out_flags;

    // The top NaN payload bit is always forced to 1, so flq[52:51] never reach the result.
    logic        w_unused;
    assign w_unused = ^bus.flq[52:51];

    assign w_s2_open  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_open;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_s1_load  = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_res   = r_out_res;
    assign bus.out_flags = r_out_flags;

    always_comb begin
        w_eq_ext = {bus.eq[12], bus.eq};
        w_m_norm = {bus.fq[54:0], 1'b0};
        w_e      = w_eq_ext - 14'd1;
        if (bus.fq[56]) begin
            w_m_norm = {bus.fq[56:2], bus.fq[1] | bus.fq[0]};
            w_e      = w_eq_ext + 14'd1;
        end else if (bus.fq[55]) begin
            w_m_norm = bus.fq[55:0];
            w_e      = w_eq_ext;
        end
        w_eb   = w_e + (bus.db ? L_BIAS_D : L_BIAS_S);
        w_tiny = w_eb[13] || (w_eb == 14'd0);
    end

`ifdef FP_RND_FTZ_EN
    assign w_m_s1  = w_m_norm;
    assign w_eb_s1 = w_eb;
`else
    logic [13:0]  w_sh_raw;
    logic [5:0]   w_sh;
    logic [119:0] w_ext;

    // The 64 guard bits below the significand catch everything a 58-bit shift can push out.
    always_comb begin
        w_sh_raw = 14'd1 - w_eb;
        w_sh     = (w_sh_raw > 14'd58) ? 6'd58 : w_sh_raw[5:0];
        w_ext    = {w_m_norm, 64'd0} >> w_sh;
        w_m_s1   = w_m_norm;
        w_eb_s1  = w_eb;
        if (w_tiny) begin
            w_m_s1  = {w_ext[119:65], w_ext[64] | (|w_ext[63:0])};
            w_eb_s1 = 14'd0;
        end
    end
`endif

    always_comb begin
        if (r_s1_db) begin
            w_r   = r_s1_m[2];
            w_s   = |r_s1_m[1:0];
            w_lsb = r_s1_m[3];
        end else begin
            w_r   = r_s1_m[31];
            w_s   = |r_s1_m[30:0];
            w_lsb = r_s1_m[32];
        end

        case (r_s1_rm)
            RM_RNE:  w_inc = w_r && (w_s || w_lsb);
            RM_RZ:   w_inc = 1'b0;
            RM_RU:   w_inc = !r_s1_sq && (w_r || w_s);
            default: w_inc = r_s1_sq && (w_r || w_s);
        endcase
        w_inx = w_r || w_s;

        w_sum_d = {1'b0, r_s1_m[55:3]}  + {53'd0, w_inc};
        w_sum_s = {1'b0, r_s1_m[55:32]} + {24'd0, w_inc};
        w_carry = r_s1_db ? w_sum_d[53] : w_sum_s[24];
        w_hid   = r_s1_db ? w_sum_d[52] : w_sum_s[23];

        // A denormal that rounds into the hidden bit becomes the smallest normal.
        if (w_carry) begin
            w_eb_r = r_s1_eb + 14'd1;
        end else if ((r_s1_eb == 14'd0) && w_hid) begin
            w_eb_r = 14'd1;
        end else begin
            w_eb_r = r_s1_eb;
        end

        w_ovf    = !w_eb_r[13] && (w_eb_r >= (r_s1_db ? L_EMAX_D : L_EMAX_S));
        w_to_inf = (r_s1_rm == RM_RNE) || ((r_s1_rm == RM_RU) && !r_s1_sq) ||
                   ((r_s1_rm == 2'b11) && r_s1_sq);

        w_res   = 64'd0;
        w_f_ovf = 1'b0;
        w_f_unf = 1'b0;
        w_f_inx = 1'b0;
        if (r_s1_nan) begin
            w_res = r_s1_db ? {1'b0, 11'h7FF, 1'b1, r_s1_nan_frac[50:0]}
                            : {32'd0, 1'b0, 8'hFF, 1'b1, r_s1_nan_frac[50:29]};
        end else if (r_s1_inf) begin
            w_res = r_s1_db ? {r_s1_sq, 11'h7FF, 52'd0} : {32'd0, r_s1_sq, 8'hFF, 23'd0};
        end else if (r_s1_zero) begin
            w_res = r_s1_db ? {r_s1_sq, 63'd0} : {32'd0, r_s1_sq, 31'd0};
`ifdef FP_RND_FTZ_EN
        end else if (r_s1_tiny) begin
            w_res   = r_s1_db ? {r_s1_sq, 63'd0} : {32'd0, r_s1_sq, 31'd0};
            w_f_unf = 1'b1;
            w_f_inx = 1'b1;
`endif
        end else if (w_ovf) begin
            w_f_ovf = 1'b1;
            w_f_inx = 1'b1;
            w_f_unf = r_s1_tiny;
            if (w_to_inf) begin
                w_res = r_s1_db ? {r_s1_sq, 11'h7FF, 52'd0} : {32'd0, r_s1_sq, 8'hFF, 23'd0};
            end else begin
                w_res = r_s1_db ? {r_s1_sq, 11'h7FE, {52{1'b1}}}
                                : {32'd0, r_s1_sq, 8'hFE, {23{1'b1}}};
            end
        end else begin
            w_f_inx = w_inx;
            w_f_unf = r_s1_tiny && w_inx;
            w_res   = r_s1_db ? {r_s1_sq, w_eb_r[10:0], w_sum_d[51:0]}
                              : {32'd0, r_s1_sq, w_eb_r[7:0], w_sum_s[22:0]};
        end
        w_flags = {r_s1_inv, r_s1_dbz, w_f_ovf, w_f_unf, w_f_inx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s1_m        <= 56'd0;
            r_s1_eb       <= 14'd0;
            r_s1_tiny     <= 1'b0;
            r_s1_sq       <= 1'b0;
            r_s1_db       <= 1'b0;
            r_s1_rm       <= 2'b00;
            r_s1_zero     <= 1'b0;
            r_s1_inf      <= 1'b0;
            r_s1_nan      <= 1'b0;
            r_s1_inv      <= 1'b0;
            r_s1_dbz      <= 1'b0;
            r_s1_nan_frac <= 51'd0;
            r_out_res     <= 64'd0;
            r_out_flags   <= 5'd0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_s1_load) begin
                r_s1_m        <= w_m_s1;
                r_s1_eb       <= w_eb_s1;
                r_s1_tiny     <= w_tiny;
                r_s1_sq       <= bus.sq;
                r_s1_db       <= bus.db;
                r_s1_rm       <= bus.rm;
                r_s1_zero     <= bus.flq[57];
                r_s1_inf      <= bus.flq[56];
                r_s1_nan      <= bus.flq[55];
                r_s1_inv      <= bus.flq[54];
                r_s1_dbz      <= bus.flq[53];
                r_s1_nan_frac <= bus.flq[50:0];
            end
            if (w_s2_open) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv) begin
                r_out_res   <= w_res;
                r_out_flags <= w_flags;
            end
        end
    end
endmodule
